// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and types for the MIPS general-purpose register file
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port: decode/mux, $0 masking, optional forwarding
// Write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
import regfile_pkg::*;

module regfile_rdport #(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM    = 2**ADDR_W
) (
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [(NUM-1)*DATA_W-1:0] regs_flat,
  output logic [DATA_W-1:0]        rdata
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] w_stored;
  logic              w_hit;

  // Slot i-1 of regs_flat holds register i; index 0 falls through to zero.
  always_comb begin
    w_stored = '0;
    for (int i = 1; i < NUM; i++) begin
      if (raddr == ADDR_W'(i)) begin
        w_stored = regs_flat[(i-1)*DATA_W +: DATA_W];
      end
    end
  end

  assign w_hit = BYPASS && we && (waddr != '0) && (raddr == waddr);

  always_comb begin
    rdata = '0;
    if (rst) begin
      rdata = w_hit ? wdata : w_stored;
    end
  end

endmodule

// File: rtl/regfiles.sv
// rtl/regfiles.sv - 32 x 32-bit MIPS register file, two async read ports, one sync write port
// Optional forwarding build: define REGFILE_BYPASS_EN.
import regfile_pkg::*;

module regfiles #(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NUM = 2**ADDR_W;

  logic [(NUM-1)*DATA_W-1:0] w_regs_flat;

  // Flop array rather than RAM so reset clears every entry asynchronously; $0 has no storage.
  for (genvar g = 1; g < NUM; g++) begin : g_reg
    logic [DATA_W-1:0] r_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_reg <= '0;
      end else if (we && (waddr == ADDR_W'(g))) begin
        r_reg <= wdata;
      end
    end

    assign w_regs_flat[(g-1)*DATA_W +: DATA_W] = r_reg;
  end

  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM    (NUM)
  ) u_rdport1 (
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr1),
    .regs_flat (w_regs_flat),
    .rdata     (rdata1)
  );

  regfile_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM    (NUM)
  ) u_rdport2 (
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr2),
    .regs_flat (w_regs_flat),
    .rdata     (rdata2)
  );

endmodule

// File: tb/tb_regfiles.sv
// tb/tb_regfiles.sv - directed self-checking bench for regfiles (both REGFILE_BYPASS_EN builds)
import regfile_pkg::*;

module tb_regfiles;

  logic      clk;
  logic      rst;
  logic      we;
  reg_addr_t waddr;
  reg_data_t wdata;
  reg_addr_t raddr1;
  reg_addr_t raddr2;
  reg_data_t rdata1;
  reg_data_t rdata2;

  int checks;
  int failures;

  regfiles dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input reg_addr_t a, input reg_data_t d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 32'hdeadbeef;
    raddr1 = 5'd9; raddr2 = 5'd9;
    tick(); tick();
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
    we = 1'b0;
    #2 rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      raddr1 = reg_addr_t'(i); raddr2 = reg_addr_t'(31 - i);
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_clear r%0d rdata1=%h rdata2=%h expected 0", i, rdata1, rdata2);
      end
    end
  endtask

  task automatic test_write_r0();
    write_reg(5'd0, 32'h0000ffff);
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL write_r0 rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
  endtask

  task automatic test_write_r1();
    write_reg(5'd1, 32'hffff0000);
    raddr1 = 5'd0; raddr2 = 5'd1;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL write_r1_port1 rdata1=%h expected 00000000", rdata1);
    end
    checks++;
    if (rdata2 !== 32'hffff0000) begin
      failures++;
      $display("FAIL write_r1_port2 rdata2=%h expected ffff0000", rdata2);
    end
  endtask

  task automatic test_we_low();
    we = 1'b0; waddr = 5'd7; wdata = 32'hcafef00d;
    tick();
    raddr1 = 5'd7; raddr2 = 5'd1;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'hffff0000) begin
      failures++;
      $display("FAIL we_low rdata1=%h rdata2=%h expected 00000000/ffff0000", rdata1, rdata2);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; waddr = 5'd3; wdata = 32'h0f0f0f0f;
    tick();
    waddr = 5'd4; wdata = 32'hffffffff;
    tick();
    we = 1'b0;
    raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    checks++;
    if (rdata1 !== 32'h0f0f0f0f || rdata2 !== 32'hffffffff) begin
      failures++;
      $display("FAIL back_to_back rdata1=%h rdata2=%h expected 0f0f0f0f/ffffffff", rdata1, rdata2);
    end
    raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'h0f0f0f0f || rdata2 !== 32'h0f0f0f0f) begin
      failures++;
      $display("FAIL same_reg_both rdata1=%h rdata2=%h expected 0f0f0f0f", rdata1, rdata2);
    end
  endtask

  task automatic test_top_reg();
    write_reg(5'd31, 32'ha5a55a5a);
    raddr1 = 5'd31; raddr2 = 5'd30;
    #1;
    checks++;
    if (rdata1 !== 32'ha5a55a5a || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL top_reg rdata1=%h rdata2=%h expected a5a55a5a/00000000", rdata1, rdata2);
    end
  endtask

  task automatic test_async_reset();
    raddr1 = 5'd3; raddr2 = 5'd4;
    we = 1'b1; waddr = 5'd6; wdata = 32'h66666666;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
    #2 rst = 1'b1;
    tick();
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL after_reset_r3r4 rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
    raddr1 = 5'd6; raddr2 = 5'd31;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL aborted_write rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
  endtask

  task automatic test_bypass();
    reg_data_t exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h12345678;
`else
    exp_pre = 32'h0;
`endif
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    raddr1 = 5'd5; raddr2 = 5'd4;
    #1;
    checks++;
    if (rdata1 !== exp_pre) begin
      failures++;
      $display("FAIL bypass_pre rdata1=%h expected %h", rdata1, exp_pre);
    end
    checks++;
    if (rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL bypass_other_port rdata2=%h expected 00000000", rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_post rdata1=%h expected 12345678", rdata1);
    end
    we = 1'b1; waddr = 5'd0; wdata = 32'hffffffff;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL bypass_r0 rdata1=%h rdata2=%h expected 0", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    test_reset();
    test_write_r0();
    test_write_r1();
    test_we_low();
    test_back_to_back();
    test_top_reg();
    test_async_reset();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
